// File: rtl/sha256_kw_schedule_if.sv
// SHA-256 message-schedule stage bus.
// Host/ROM side is master, schedule stage is slave.
interface sha256_kw_schedule_if;
  logic         start;
  logic [511:0] block;
  logic [5:0]   round;
  logic [31:0]  Kt;
  logic [31:0]  kw;
  logic [5:0]   kw_round;
  logic         kw_valid;
  logic         busy;
  logic         done;

  modport master (
    output start,
    output block,
    output Kt,
    input  round,
    input  kw,
    input  kw_round,
    input  kw_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  block,
    input  Kt,
    output round,
    output kw,
    output kw_round,
    output kw_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/sha256_kw_schedule.sv
// SHA-256 message schedule: 16-word sliding window,
// Wt delayed to meet the ROM Kt, registered Kt+Wt.
module sha256_kw_schedule #(
  parameter int K_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  sha256_kw_schedule_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(K_LATENCY);
  localparam int         TAIL       = K_LATENCY - 1;

  state_t      r_state;
  logic [5:0]  r_round;
  logic [1:0]  r_drain;
  logic        r_busy;

  logic [31:0] r_w [16];

  logic        r_dv [K_LATENCY];
  logic [31:0] r_dw [K_LATENCY];
  logic [5:0]  r_dr [K_LATENCY];

  logic [31:0] r_kw;
  logic [5:0]  r_kw_round;
  logic        r_kw_valid;
  logic        r_done;

  logic        w_accept;
  logic        w_run;
  logic [31:0] w_new;

  function automatic logic [31:0] s0(
    input logic [31:0] x
  );
    s0 = {x[6:0], x[31:7]}
       ^ {x[17:0], x[31:18]}
       ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(
    input logic [31:0] x
  );
    s1 = {x[16:0], x[31:17]}
       ^ {x[18:0], x[31:19]}
       ^ (x >> 10);
  endfunction

  assign w_accept = (r_state == S_IDLE)
                  && bus.start;
  assign w_run    = (r_state == S_RUN);
  assign w_new    = s1(r_w[14]) + r_w[9]
                  + s0(r_w[1]) + r_w[0];

  // Control FSM: round counter, busy and drain timing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_round <= 6'd0;
      r_drain <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (bus.start) begin
            r_round <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        (r_state == S_RUN): begin
          if (r_round == 6'd63) begin
            r_drain <= 2'd0;
            r_state <= S_DRAIN;
          end else begin
            r_round <= r_round + 6'd1;
          end
        end
        (r_state == S_DRAIN): begin
          if (r_drain == DRAIN_LAST) begin
            r_busy  <= 1'b0;
            r_round <= 6'd0;
            r_state <= S_IDLE;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_round <= 6'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Window: load at accept, slide and expand while running.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= bus.block[511 - 32*i -: 32];
      end
    end else if (w_run) begin
      for (int i = 0; i < 15; i++) begin
        r_w[i] <= r_w[i + 1];
      end
      r_w[15] <= w_new;
    end
  end

  // Delay-line valid bits; cleared on reset to abort a block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < K_LATENCY; i++) begin
        r_dv[i] <= 1'b0;
      end
    end else begin
      r_dv[0] <= w_run;
      for (int i = 1; i < K_LATENCY; i++) begin
        r_dv[i] <= r_dv[i - 1];
      end
    end
  end

  // Delay-line payload: Wt and its round index.
  always_ff @(posedge clk) begin
    r_dw[0] <= r_w[0];
    r_dr[0] <= r_round;
    for (int i = 1; i < K_LATENCY; i++) begin
      r_dw[i] <= r_dw[i - 1];
      r_dr[i] <= r_dr[i - 1];
    end
  end

  // Output stage: add the aligned Kt to the delayed Wt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_kw       <= 32'd0;
      r_kw_round <= 6'd0;
      r_kw_valid <= 1'b0;
      r_done     <= 1'b0;
    end else if (r_dv[TAIL]) begin
      r_kw       <= bus.Kt + r_dw[TAIL];
      r_kw_round <= r_dr[TAIL];
      r_kw_valid <= 1'b1;
      r_done     <= (r_dr[TAIL] == 6'd63);
    end else begin
      r_kw_valid <= 1'b0;
      r_done     <= 1'b0;
    end
  end

  assign bus.round    = r_round;
  assign bus.busy     = r_busy;
  assign bus.kw       = r_kw;
  assign bus.kw_round = r_kw_round;
  assign bus.kw_valid = r_kw_valid;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_sha256_kw_schedule.sv
// Directed bench for sha256_kw_schedule, run with
// K_LATENCY=1 and K_LATENCY=2 side by side.
module tb_sha256_kw_schedule;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha256_kw_schedule_if if1 ();
  sha256_kw_schedule_if if2 ();

  sha256_kw_schedule #(.K_LATENCY(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  sha256_kw_schedule #(.K_LATENCY(2)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if2.slave)
  );

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ROM models: 1-cycle for dut1, 2-cycle for dut2.
  logic [31:0] rom2_a;
  always_ff @(posedge clk) begin
    if1.Kt <= KT[if1.round];
    rom2_a <= KT[if2.round];
    if2.Kt <= rom2_a;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_w [64];

  function automatic logic [31:0] ror(
    input logic [31:0] x, input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic gen_w(input logic [511:0] b);
    for (int i = 0; i < 16; i++)
      exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (ror(exp_w[i-2], 17)
                 ^ ror(exp_w[i-2], 19)
                 ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (ror(exp_w[i-15], 7)
                 ^ ror(exp_w[i-15], 18)
                 ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
  endtask

  task automatic chk(
    input string tag, input int cyc,
    input logic [31:0] obs, input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dut(
    input string nm, input int k, input int c,
    input logic [5:0] rnd, input logic bsy,
    input logic kv, input logic dn,
    input logic [5:0] kr, input logic [31:0] kw
  );
    int er;
    bit vin;
    er  = (c <= 64) ? c - 1
        : ((c <= 65 + k) ? 63 : 0);
    vin = (c >= 2 + k) && (c <= 65 + k);
    chk({nm, ".round"}, c, 32'(rnd), 32'(er));
    chk({nm, ".busy"}, c, 32'(bsy),
        32'(c <= 65 + k));
    chk({nm, ".kw_valid"}, c, 32'(kv), 32'(vin));
    chk({nm, ".done"}, c, 32'(dn),
        32'(c == 65 + k));
    if (vin) begin
      chk({nm, ".kw_round"}, c, 32'(kr),
          32'(c - 2 - k));
      chk({nm, ".kw"}, c, kw,
          exp_w[c-2-k] + KT[c-2-k]);
    end
  endtask

  task automatic drive(
    input logic s, input logic [511:0] b
  );
    if1.start = s;
    if2.start = s;
    if1.block = b;
    if2.block = b;
  endtask

  function automatic logic [511:0] rnd_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++)
      b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  // Full block run; start is driven in cycle 0.
  task automatic run_block(
    input logic [511:0] blk, input int pulse_at,
    input bit hand
  );
    gen_w(blk);
    drive(1'b1, blk);
    for (int c = 1; c <= 69; c++) begin
      step();
      drive(c == pulse_at, rnd_block());
      check_dut("d1", 1, c, if1.round, if1.busy,
                if1.kw_valid, if1.done,
                if1.kw_round, if1.kw);
      check_dut("d2", 2, c, if2.round, if2.busy,
                if2.kw_valid, if2.done,
                if2.kw_round, if2.kw);
      if (hand && c == 3)
        chk("abc_kw0_d1", c, if1.kw, 32'hA3EC9318);
      if (hand && c == 4)
        chk("abc_kw0_d2", c, if2.kw, 32'hA3EC9318);
      if (hand && c == 19)
        chk("abc_kw16", c, if1.kw, 32'h45FDCD41);
      if (hand && c == 20)
        chk("abc_kw17", c, if1.kw, 32'hEFCD4786);
    end
    drive(1'b0, '0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, ".d1.round"}, 0, 32'(if1.round), 0);
    chk({nm, ".d1.busy"}, 0, 32'(if1.busy), 0);
    chk({nm, ".d1.kw_valid"}, 0,
        32'(if1.kw_valid), 0);
    chk({nm, ".d1.done"}, 0, 32'(if1.done), 0);
    chk({nm, ".d2.round"}, 0, 32'(if2.round), 0);
    chk({nm, ".d2.busy"}, 0, 32'(if2.busy), 0);
    chk({nm, ".d2.kw_valid"}, 0,
        32'(if2.kw_valid), 0);
    chk({nm, ".d2.done"}, 0, 32'(if2.done), 0);
  endtask

  logic [511:0] abc;
  logic [511:0] blk;

  initial begin
    abc = {32'h61626380, 448'h0, 32'h00000018};
    drive(1'b0, '0);

    reset_n = 1'b0;
    step();
    step();
    check_idle("reset");
    chk("reset.d1.kw", 0, if1.kw, 0);
    chk("reset.d1.kw_round", 0,
        32'(if1.kw_round), 0);
    chk("reset.d2.kw", 0, if2.kw, 0);
    reset_n = 1'b1;
    step();

    run_block(abc, -1, 1'b1);

    for (int n = 0; n < 3; n++)
      run_block(rnd_block(), (n == 1) ? 10 : -1,
                1'b0);

    blk = rnd_block();
    gen_w(blk);
    drive(1'b1, blk);
    for (int c = 1; c <= 31; c++) begin
      step();
      drive(1'b0, '0);
    end
    chk("abort.pre_round", 31, 32'(if1.round), 30);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_idle("abort");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort.d1.quiet", c, 32'(if1.kw_valid), 0);
      chk("abort.d2.quiet", c, 32'(if2.kw_valid), 0);
    end

    run_block(rnd_block(), -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
